btn_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the per-pixel colour/game-logic block. It turns the raw board buttons into clean control strobes for that block.
- Per button: 2-FF synchroniser, counter debouncer, one-cycle press/release strobes, and auto-repeat on selected buttons (held left/right/down keeps moving the piece).
- Runs entirely in the 25 MHz pixel clock domain, so the consumer gets single-cycle pulses in its own domain.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce_1b.sv | 119 +++++++++++
 rtl/btn_conditioner.sv | 36 +++
 tb/tb_btn_conditioner.sv | 112 +++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: button indices, repeat FSM
// encoding and default 25 MHz timing.
package btn_pkg;

  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam int DEF_NBTN         = 5;
  localparam int DEF_DEBOUNCE_CYC = 250000;   // 10 ms
  localparam int DEF_REPEAT_DELAY = 6250000;  // 250 ms
  localparam int DEF_REPEAT_RATE  = 2500000;  // 100 ms

endpackage

// File: rtl/btn_debounce_1b.sv
// One button: 2-FF synchroniser, counter debouncer, press/release strobes and
// optional auto-repeat (built only when BTN_REPEAT_EN is defined).
module btn_debounce_1b
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic CLK25M,
  input  logic RST,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE
);

  localparam int DW = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = (RMAX < 2) ? 1 : $clog2(RMAX + 1);

`ifdef BTN_REPEAT_EN
  localparam bit RPT_ON = REPEAT_EN;
`else
  localparam bit RPT_ON = 1'b0 & REPEAT_EN;
`endif

  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("btn_debounce_1b: timing parameters must be >= 1");
  end

  logic          sync_p0, sync_p1;
  logic          level_q, press_q, release_q;
  logic [DW-1:0] db_cnt;
  logic          accept;
  logic          rpt_due;

  // Level change is accepted once the mismatch has persisted through a full count.
  assign accept = (sync_p1 != level_q) && (db_cnt == DW'(DEBOUNCE_CYC));

  always_ff @(posedge CLK25M) begin
    if (RST) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_p0   <= BTN_IN;
      sync_p1   <= sync_p0;
      if (accept) begin
        level_q <= ~level_q;
        db_cnt  <= '0;
      end else if (sync_p1 != level_q) begin
        db_cnt  <= db_cnt + 1'b1;
      end else begin
        db_cnt  <= '0;
      end
      press_q   <= (accept && !level_q) || rpt_due;
      release_q <= accept && level_q;
    end
  end

  if (RPT_ON) begin : g_repeat
    logic [1:0]    st;
    logic [RW-1:0] rpt_cnt;
    logic          hit;

    always_comb begin
      hit = 1'b0;
      case (st)
        ST_DELAY:  hit = (rpt_cnt == RW'(REPEAT_DELAY - 1));
        ST_REPEAT: hit = (rpt_cnt == RW'(REPEAT_RATE - 1));
        default:   hit = 1'b0;
      endcase
    end

    // An accept while held is the release, which masks a repeat due that cycle.
    assign rpt_due = hit && !accept;

    always_ff @(posedge CLK25M) begin
      if (RST) begin
        st      <= ST_IDLE;
        rpt_cnt <= '0;
      end else if (accept) begin
        st      <= level_q ? ST_IDLE : ST_DELAY;
        rpt_cnt <= '0;
      end else begin
        case (st)
          ST_DELAY: begin
            if (hit) begin
              st      <= ST_REPEAT;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (hit) rpt_cnt <= '0;
            else     rpt_cnt <= rpt_cnt + 1'b1;
          end
          default: begin
            st      <= ST_IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
  end else begin : g_no_repeat
    assign rpt_due = 1'b0;
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Raw buttons -> debounced levels and single-cycle press/release strobes in the
// 25 MHz pixel domain. Auto-repeat is built only with `define BTN_REPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int              NBTN         = DEF_NBTN,
  parameter int              DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int              REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int              REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [NBTN-1:0] REPEAT_MASK  = 5'b01110
) (
  input  logic            CLK25M,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN_IN,
  output logic [NBTN-1:0] BTN_LEVEL,
  output logic [NBTN-1:0] BTN_PRESS,
  output logic [NBTN-1:0] BTN_RELEASE
);

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce_1b #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_db (
      .CLK25M      (CLK25M),
      .RST         (RST),
      .BTN_IN      (BTN_IN[i]),
      .BTN_LEVEL   (BTN_LEVEL[i]),
      .BTN_PRESS   (BTN_PRESS[i]),
      .BTN_RELEASE (BTN_RELEASE[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing (4/10/3).
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int         NB    = 5;
  localparam int         DEB   = 4;
  localparam int         DLY   = 10;
  localparam int         RATE  = 3;
  localparam logic [4:0] MASK  = 5'b01110;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          CLK25M = 1'b0;
  logic          RST;
  logic [NB-1:0] BTN_IN;
  logic [NB-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;

  int n_chk  = 0;
  int n_pass = 0;

  btn_conditioner #(
    .NBTN         (NB),
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (DLY),
    .REPEAT_RATE  (RATE),
    .REPEAT_MASK  (MASK)
  ) dut (
    .CLK25M      (CLK25M),
    .RST         (RST),
    .BTN_IN      (BTN_IN),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE)
  );

  always #20 CLK25M = ~CLK25M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK25M);
    #1;
  endtask

  // Press strobe at p, repeats from p+DLY every RATE while i < r.
  function automatic bit exp_press(int i, int p, int r, bit rep);
    return (i == p && i < r) ||
           (rep && i >= p + DLY && ((i - p - DLY) % RATE) == 0 && i < r);
  endfunction

  // Hold button idx for `hold` cycles from cycle 0; optional 1-cycle RST at cycle rst_at.
  task automatic scen(input string name, input int idx, input int hold, input int rst_at);
    int  p2, r, seg1_end;
    bit  rep, lv, pr, rl;
    logic [NB-1:0] one;
    one      = NB'(1) << idx;
    rep      = REP && MASK[idx];
    r        = hold + DEB + 2;
    seg1_end = (rst_at < 0) ? r : rst_at;
    p2       = (rst_at < 0) ? 100000 : rst_at + DEB + 3;
    for (int i = 0; i < r + 6; i++) begin
      BTN_IN = (i < hold) ? one : '0;
      RST    = (i == rst_at);
      tick();
      lv = (i >= DEB + 2 && i < seg1_end) || (i >= p2 && i < r);
      pr = exp_press(i, DEB + 2, seg1_end, rep) || exp_press(i, p2, r, rep);
      rl = (i == r);
      chk($sformatf("%s level c%0d", name, i), 32'(BTN_LEVEL),   32'(lv ? one : '0));
      chk($sformatf("%s press c%0d", name, i), 32'(BTN_PRESS),   32'(pr ? one : '0));
      chk($sformatf("%s release c%0d", name, i), 32'(BTN_RELEASE), 32'(rl ? one : '0));
    end
    RST = 1'b0;
  endtask

  initial begin
    RST    = 1'b1;
    BTN_IN = '0;
    repeat (3) tick();
    chk("reset level",   32'(BTN_LEVEL),   32'h0);
    chk("reset press",   32'(BTN_PRESS),   32'h0);
    chk("reset release", 32'(BTN_RELEASE), 32'h0);
    RST = 1'b0;
    repeat (3) tick();

    scen("hold_L", BTN_L, 40, -1);

    // 3 high / 2 low bounce never survives the debounce window
    for (int i = 0; i < 30; i++) begin
      BTN_IN = (i < 20 && (i % 5) < 3) ? NB'(1) << BTN_U : '0;
      tick();
      chk($sformatf("bounce level c%0d", i),   32'(BTN_LEVEL),   32'h0);
      chk($sformatf("bounce press c%0d", i),   32'(BTN_PRESS),   32'h0);
      chk($sformatf("bounce release c%0d", i), 32'(BTN_RELEASE), 32'h0);
    end

    scen("norep_C", BTN_C, 50, -1);
    scen("collide_L", BTN_L, 13, -1);
    scen("rst_R", BTN_R, 30, 12);
    scen("hold_D", BTN_D, 40, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
